multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_pkg.sv | 17 +
 rtl/multicycle_ctrl_if.sv | 10 +
 rtl/multicycle_ctrl_wait_timer.sv | 18 +
 rtl/multicycle_ctrl.sv | 84 ++++++++
 tb/tb_multicycle_ctrl.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg: state enumeration, opcode constants and ALU select encodings
package multicycle_ctrl_pkg;
    typedef enum logic [3:0] {
        FETCH, DECODE, EX_R, EX_I, MEM_ADDR, MEM_RD, LD_WB, MEM_WR, BRANCH, ALU_WB, FAULT
    } state_t;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] SRCB_RS2  = 2'd0;
    localparam logic [1:0] SRCB_4    = 2'd1;
    localparam logic [1:0] SRCB_IMM  = 2'd2;
endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: shared-memory request/ready handshake between controller and memory
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_read;
    logic mem_write;
    logic iord;
    logic mem_ready;
    modport master(output mem_req, mem_read, mem_write, iord, input mem_ready);
    modport slave(input mem_req, mem_read, mem_write, iord, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl_wait_timer.sv
// mc_wait_timer: counts mem_ready-low cycles in a memory state and flags the timeout cycle
module mc_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expired
);
    localparam int W = $clog2(MEM_TIMEOUT + 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt <= '0;
        else if (clear) cnt <= '0;
        else if (inc) cnt <= cnt + 1'b1;
    assign expired = cnt == W'(MEM_TIMEOUT - 1);
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle RISC-V control FSM; define MULTICYCLE_CTRL_PERF_EN for instret/cycles counters
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [6:0]               opcode,
    input  logic                     zero,
    multicycle_ctrl_if.master        mem,
    output logic                     ir_write,
    output logic                     pc_write,
    output logic                     aluout_write,
    output logic                     reg_write,
    output logic                     mem_to_reg,
    output logic                     pc_src,
    output logic                     alu_src_a,
    output logic [1:0]               alu_src_b,
    output logic [1:0]               alu_op,
    output logic [3:0]               state,
    output logic                     fault
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [31:0]              instret,
    output logic [31:0]              cycles
`endif
);
    state_t cur, nxt;
    logic in_mem, expired, fetch_done;
    assign in_mem = cur inside {FETCH, MEM_RD, MEM_WR};
    mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk(clk),
        .rst(rst),
        .clear(nxt != cur),
        .inc(in_mem && !mem.mem_ready),
        .expired(expired)
    );
    always_ff @(posedge clk or negedge rst)
        if (!rst) cur <= FETCH;
        else cur <= nxt;
    always_comb begin
        nxt = cur;
        case (cur)
            FETCH:      nxt = mem.mem_ready ? DECODE : expired ? FAULT : FETCH;
            DECODE:     nxt = opcode == OP_R ? EX_R :
                              opcode == OP_I ? EX_I :
                              (opcode == OP_LOAD || opcode == OP_STORE) ? MEM_ADDR :
                              opcode == OP_BRANCH ? BRANCH : FAULT;
            EX_R, EX_I: nxt = ALU_WB;
            MEM_ADDR:   nxt = opcode == OP_STORE ? MEM_WR : MEM_RD;
            MEM_RD:     nxt = mem.mem_ready ? LD_WB : expired ? FAULT : MEM_RD;
            MEM_WR:     nxt = mem.mem_ready ? FETCH : expired ? FAULT : MEM_WR;
            LD_WB, ALU_WB, BRANCH: nxt = FETCH;
            default:    nxt = FAULT;
        endcase
    end
    assign fetch_done    = cur == FETCH && mem.mem_ready && rst;
    assign mem.mem_req   = in_mem;
    assign mem.mem_read  = cur == FETCH || cur == MEM_RD;
    assign mem.mem_write = cur == MEM_WR;
    assign mem.iord      = cur == MEM_RD || cur == MEM_WR;
    assign ir_write      = fetch_done;
    assign pc_write      = fetch_done || (cur == BRANCH && zero);
    assign aluout_write  = cur inside {DECODE, EX_R, EX_I, MEM_ADDR};
    assign reg_write     = cur inside {ALU_WB, LD_WB};
    assign mem_to_reg    = cur == LD_WB;
    assign pc_src        = cur == BRANCH;
    assign alu_src_a     = cur inside {EX_R, EX_I, MEM_ADDR, BRANCH};
    assign alu_src_b     = cur == FETCH ? SRCB_4 : cur inside {DECODE, EX_I, MEM_ADDR} ? SRCB_IMM : SRCB_RS2;
    assign alu_op        = cur inside {EX_R, EX_I} ? ALU_FUNCT : cur == BRANCH ? ALU_SUB : ALU_ADD;
    assign state         = cur;
    assign fault         = cur == FAULT;
`ifdef MULTICYCLE_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            instret <= '0;
            cycles  <= '0;
        end else begin
            if (cur != FAULT) cycles <= cycles + 32'd1;
            if (nxt == FETCH && cur inside {ALU_WB, LD_WB, MEM_WR, BRANCH}) instret <= instret + 32'd1;
        end
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed and randomized instruction streams checked against a per-instruction state-sequence model
module tb_multicycle_ctrl;
    localparam int T = 16;
    localparam int S_FETCH = 0, S_DECODE = 1, S_EX_R = 2, S_EX_I = 3, S_MEM_ADDR = 4, S_MEM_RD = 5;
    localparam int S_LD_WB = 6, S_MEM_WR = 7, S_BRANCH = 8, S_ALU_WB = 9, S_FAULT = 10;
    localparam logic [6:0] R_OP = 7'b0110011, I_OP = 7'b0010011, LD_OP = 7'b0000011;
    localparam logic [6:0] ST_OP = 7'b0100011, BR_OP = 7'b1100011, BAD_OP = 7'b1111111;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [6:0] opcode = '0;
    logic zero = 1'b0;
    logic mem_ready = 1'b0;
    logic ir_write, pc_write, aluout_write, reg_write, mem_to_reg, pc_src, alu_src_a, fault;
    logic [1:0] alu_src_b, alu_op;
    logic [3:0] state;
    logic [15:0] obs;
    int n_checks = 0;
    int n_fail = 0;
    int m_ret = 0;
    int m_cyc = 0;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] instret, cycles;
`endif
    multicycle_ctrl_if mif();
    assign mif.mem_ready = mem_ready;
    multicycle_ctrl #(.MEM_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem(mif.master),
        .ir_write(ir_write), .pc_write(pc_write), .aluout_write(aluout_write),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .state(state), .fault(fault)
`ifdef MULTICYCLE_CTRL_PERF_EN
        , .instret(instret), .cycles(cycles)
`endif
    );
    always #5 clk = ~clk;
    assign obs = {mif.mem_req, mif.mem_read, mif.mem_write, mif.iord, ir_write, pc_write, aluout_write,
                  reg_write, mem_to_reg, pc_src, alu_src_a, alu_src_b, alu_op, fault};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_outs(input int s, input logic rdy, input logic z);
        logic req, rd, wr, io, irw, pcw, aw, rw, m2r, ps, sa, f;
        logic [1:0] sb, op;
        {req, rd, wr, io, irw, pcw, aw, rw, m2r, ps, sa, f} = '0;
        sb = 2'd0;
        op = 2'd0;
        case (s)
            S_FETCH:    begin req = 1; rd = 1; sb = 2'd1; irw = rdy; pcw = rdy; end
            S_DECODE:   begin sb = 2'd2; aw = 1; end
            S_EX_R:     begin sa = 1; op = 2'b10; aw = 1; end
            S_EX_I:     begin sa = 1; sb = 2'd2; op = 2'b10; aw = 1; end
            S_MEM_ADDR: begin sa = 1; sb = 2'd2; aw = 1; end
            S_MEM_RD:   begin req = 1; io = 1; rd = 1; end
            S_LD_WB:    begin rw = 1; m2r = 1; end
            S_MEM_WR:   begin req = 1; io = 1; wr = 1; end
            S_BRANCH:   begin sa = 1; op = 2'b01; ps = 1; pcw = z; end
            S_ALU_WB:   rw = 1;
            S_FAULT:    f = 1;
            default:    ;
        endcase
        return {req, rd, wr, io, irw, pcw, aw, rw, m2r, ps, sa, sb, op, f};
    endfunction

    task automatic step(input int s, input logic rdy);
        mem_ready = rdy;
        #1;
        check("state", 32'(state), 32'(s));
        check("outs", 32'(obs), 32'(exp_outs(s, rdy, zero)));
`ifdef MULTICYCLE_CTRL_PERF_EN
        check("instret", instret, 32'(m_ret));
        check("cycles", cycles, 32'(m_cyc));
`endif
        if (s != S_FAULT) m_cyc++;
        if (s == S_ALU_WB || s == S_LD_WB || s == S_BRANCH || (s == S_MEM_WR && rdy)) m_ret++;
        @(negedge clk);
    endtask

    task automatic check_reset_state();
        check("rst_state", 32'(state), 32'(S_FETCH));
        check("rst_outs", 32'(obs), 32'(exp_outs(S_FETCH, 1'b0, zero)));
`ifdef MULTICYCLE_CTRL_PERF_EN
        check("rst_instret", instret, 32'd0);
        check("rst_cycles", cycles, 32'd0);
`endif
    endtask

    task automatic reset_seq();
        rst = 1'b0;
        mem_ready = 1'b1;
        #1;
        check_reset_state();
        m_ret = 0;
        m_cyc = 0;
        @(posedge clk);
        #1;
        check_reset_state();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic fault_and_reset(input int hold);
        for (int i = 0; i < hold; i++) step(S_FAULT, 1'($urandom));
        reset_seq();
    endtask

    task automatic mem_phase(input int s, input int w, output bit ok);
        ok = 1'b1;
        for (int i = 0; i <= w; i++) begin
            if (i == T) begin
                fault_and_reset(3);
                ok = 1'b0;
                return;
            end
            step(s, i == w);
        end
    endtask

    task automatic instr(input logic [6:0] op, input logic z, input int fw, input int mw, input int hold);
        bit ok;
        opcode = op;
        zero = z;
        mem_phase(S_FETCH, fw, ok);
        if (!ok) return;
        step(S_DECODE, 1'($urandom));
        if (op == R_OP || op == I_OP) begin
            step(op == R_OP ? S_EX_R : S_EX_I, 1'($urandom));
            step(S_ALU_WB, 1'($urandom));
        end else if (op == LD_OP || op == ST_OP) begin
            step(S_MEM_ADDR, 1'($urandom));
            mem_phase(op == LD_OP ? S_MEM_RD : S_MEM_WR, mw, ok);
            if (ok && op == LD_OP) step(S_LD_WB, 1'($urandom));
        end else if (op == BR_OP) begin
            step(S_BRANCH, 1'($urandom));
        end else begin
            fault_and_reset(hold);
        end
    endtask

    function automatic int rand_wait();
        return $urandom_range(0, 9) == 0 ? int'($urandom_range(T - 2, T + 2)) : int'($urandom_range(0, 3));
    endfunction

    initial begin
        logic [6:0] ops [6];
        ops = '{R_OP, I_OP, LD_OP, ST_OP, BR_OP, BR_OP};
        #1 rst = 1'b0;
        mem_ready = 1'b1;
        #1;
        check_reset_state();
        @(negedge clk);
        rst = 1'b1;
        instr(R_OP, 1'b0, 0, 0, 2);
        instr(I_OP, 1'b0, 1, 0, 2);
        instr(LD_OP, 1'b0, 0, 3, 2);
        instr(ST_OP, 1'b0, 2, 1, 2);
        instr(BR_OP, 1'b1, 0, 0, 2);
        instr(BR_OP, 1'b0, 0, 0, 2);
        instr(BAD_OP, 1'b0, 0, 0, 100);
        instr(R_OP, 1'b0, T, 0, 2);
        instr(R_OP, 1'b0, T - 1, 0, 2);
        instr(LD_OP, 1'b0, 0, T, 2);
        instr(ST_OP, 1'b0, 0, T - 1, 2);
        opcode = ST_OP;
        step(S_FETCH, 1'b1);
        step(S_DECODE, 1'b0);
        step(S_MEM_ADDR, 1'b0);
        step(S_MEM_WR, 1'b0);
        step(S_MEM_WR, 1'b0);
        mem_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("async_state", 32'(state), 32'(S_FETCH));
        check("async_mem_write", 32'(mif.mem_write), 32'd0);
        check_reset_state();
        m_ret = 0;
        m_cyc = 0;
        @(negedge clk);
        rst = 1'b1;
        instr(R_OP, 1'b0, T - 1, 0, 2);
        for (int n = 0; n < 300; n++) begin
            logic [6:0] op;
            op = $urandom_range(0, 7) == 0 ? 7'($urandom) : ops[$urandom_range(0, 5)];
            instr(op, 1'($urandom), rand_wait(), rand_wait(), 2);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
